tile_line_renderer: RTL

Reader side of the tile graphics memories. On each line request it walks the 20x15 tile map for one 640-pixel scanline and fetches 32x32 tile bitmaps. Each pixel is resolved through the 8-entry palette, and the 24-bit RGB result is written into an internal ping-pong line buffer. The VGA output stage reads pixels from the front half while the next line renders into the back half.

---
 rtl/tile_line_renderer.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/tile_line_renderer.sv
// tile_line_renderer
//   Renders one 640-pixel scanline per line_start. For each of the 20 tile
//   columns it reads the tile index from the tile buffer, then the four
//   graphics words of that tile's row. Each 4-bit pixel is resolved through
//   the 8-entry palette, and the RGB result goes into the back half of a
//   ping-pong line buffer. The VGA side reads the front half through
//   pix_x / pix_rgb.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   line_start          1-cycle pulse: swap halves, start rendering render_line
//   render_line[9:0]    line to render, sampled with line_start
//   busy                high while a render is in progress
//   done                1-cycle pulse after the last pixel of a line is written
//   overrun             1-cycle pulse when line_start arrives while busy
//   tb_addr/tb_rw/tb_read_data     tile buffer read port (1-cycle latency)
//   tg_addr/tg_rw/tg_read_data     tile graphics read port (1-cycle latency)
//   pal_addr/pal_rw/pal_read_data  palette read port (1-cycle latency)
//   pix_x[9:0], pix_rgb[23:0]      front-half read port, registered
//   dbg_state[2:0]      current FSM state, for observation only
//
// Handshake: there is no valid/ready pair. line_start is a single-cycle
// command that is always accepted, in any state. A line_start that arrives
// while busy abandons the current line: it raises overrun for one cycle and
// suppresses that line's done pulse. done is a single-cycle completion
// strobe with no acknowledge.
module tile_line_renderer #(
  parameter int TILE_COLS = 20,
  parameter int TILE_ROWS = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        line_start,
  input  logic [9:0]  render_line,
  output logic        busy,
  output logic        done,
  output logic        overrun,
  output logic [8:0]  tb_addr,
  output logic        tb_rw,
  input  logic [31:0] tb_read_data,
  output logic [10:0] tg_addr,
  output logic        tg_rw,
  input  logic [31:0] tg_read_data,
  output logic [2:0]  pal_addr,
  output logic        pal_rw,
  input  logic [23:0] pal_read_data,
  input  logic [9:0]  pix_x,
  output logic [23:0] pix_rgb,
  output logic [2:0]  dbg_state
);

  localparam int LINE_PIXELS = TILE_COLS * 32;
  localparam int FRAME_LINES = TILE_ROWS * 32;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_TB_REQ  = 3'd1,
    S_TB_WAIT = 3'd2,
    S_TG_REQ  = 3'd3,
    S_TG_WAIT = 3'd4,
    S_PIX     = 3'd5,
    S_FLUSH   = 3'd6
  } state_t;

  state_t state, state_next;

  logic [4:0]  col;       // tile column 0..19
  logic [1:0]  word;      // graphics word within the tile row
  logic [2:0]  pix;       // pixel within the graphics word
  logic [3:0]  idx;       // tile index of the current column
  logic [4:0]  line_q;    // row within the tile
  logic [27:0] bits_q;    // remaining nibbles of the current word, LSB first
  logic        front;     // half the VGA side reads; rendering writes ~front
  logic        wr_en;     // palette data arriving this cycle must be written
  logic [9:0]  wr_x;      // screen x of that data

  logic        line_ok;
  logic        last_pix, last_word, last_col;
  logic        ld_tile, ld_bits, pix_step, finish;

  logic [23:0] lbuf [0:2*LINE_PIXELS-1];
  logic [10:0] wr_addr, rd_addr;
  logic        rd_ok;

  assign line_ok   = (render_line < 10'(FRAME_LINES));
  assign last_pix  = (pix == 3'd7);
  assign last_word = (word == 2'd3);
  assign last_col  = (col == 5'(TILE_COLS - 1));

  assign tb_rw     = 1'b0;
  assign tg_rw     = 1'b0;
  assign pal_rw    = 1'b0;
  assign dbg_state = state;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (line_start) begin
      // Out-of-range lines only swap the halves; nothing is fetched.
      state_next = line_ok ? S_TB_REQ : S_IDLE;
    end else begin
      case (state)
        S_IDLE:    state_next = S_IDLE;
        S_TB_REQ:  state_next = S_TB_WAIT;
        S_TB_WAIT: state_next = S_TG_REQ;
        S_TG_REQ:  state_next = S_TG_WAIT;
        S_TG_WAIT: state_next = S_PIX;
        S_PIX: begin
          if (last_pix) begin
            if (!last_word)     state_next = S_TG_REQ;
            else if (!last_col) state_next = S_TB_REQ;
            else                state_next = S_FLUSH;
          end
        end
        S_FLUSH:   state_next = S_IDLE;
        default:   state_next = S_IDLE;
      endcase
    end
  end

  // A line_start overrides whatever the current state would do this cycle.
  always_comb begin
    busy     = (state != S_IDLE);
    ld_tile  = 1'b0;
    ld_bits  = 1'b0;
    pix_step = 1'b0;
    finish   = 1'b0;
    if (!line_start) begin
      case (state)
        S_TB_WAIT: ld_tile  = 1'b1;
        S_TG_WAIT: ld_bits  = 1'b1;
        S_PIX:     pix_step = 1'b1;
        S_FLUSH:   finish   = 1'b1;
        default:   ;
      endcase
    end
  end

  // ----------------------------------------------------------- datapath
  // Memory addresses are registered and change on the edge that enters the
  // state using them, so each *_REQ / PIX cycle presents a stable address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done     <= 1'b0;
      overrun  <= 1'b0;
      tb_addr  <= '0;
      tg_addr  <= '0;
      pal_addr <= '0;
      col      <= '0;
      word     <= '0;
      pix      <= '0;
      idx      <= '0;
      line_q   <= '0;
      bits_q   <= '0;
      front    <= 1'b0;
      wr_en    <= 1'b0;
      wr_x     <= '0;
    end else begin
      overrun <= line_start & busy;
      done    <= finish;
      wr_en   <= pix_step;
      if (line_start) begin
        front  <= ~front;
        line_q <= render_line[4:0];
        if (line_ok) begin
          col     <= '0;
          tb_addr <= 9'(render_line[9:5]) * 9'(TILE_COLS);
        end
      end else begin
        if (ld_tile) begin
          idx     <= tb_read_data[3:0];
          word    <= '0;
          tg_addr <= {tb_read_data[3:0], line_q, 2'b00};
        end
        if (ld_bits) begin
          // Pixel 0 goes straight to the palette; the rest wait in bits_q.
          bits_q   <= tg_read_data[31:4];
          pix      <= '0;
          pal_addr <= tg_read_data[2:0];
        end
        if (pix_step) begin
          // col*32 + word*8 + pix is a plain concatenation.
          wr_x <= {col, word, pix};
          if (!last_pix) begin
            pix      <= pix + 3'd1;
            pal_addr <= bits_q[2:0];
            bits_q   <= {4'b0000, bits_q[27:4]};
          end else if (!last_word) begin
            word    <= word + 2'd1;
            tg_addr <= {idx, line_q, word + 2'd1};
          end else if (!last_col) begin
            col     <= col + 5'd1;
            tb_addr <= tb_addr + 9'd1;
          end
        end
      end
    end
  end

  // --------------------------------------------------------- line buffer
  // Half 0 occupies entries 0..639 and half 1 occupies 640..1279.
  assign wr_addr = {1'b0, wr_x} + (front ? 11'd0 : 11'(LINE_PIXELS));
  assign rd_ok   = (pix_x < 10'(LINE_PIXELS));
  assign rd_addr = (rd_ok ? {1'b0, pix_x} : 11'd0) + (front ? 11'(LINE_PIXELS) : 11'd0);

  always_ff @(posedge clk) begin
    if (wr_en) lbuf[wr_addr] <= pal_read_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   pix_rgb <= '0;
    else if (rd_ok) pix_rgb <= lbuf[rd_addr];
    else            pix_rgb <= '0;
  end

  // Ignored fields of the fetched words.
  logic unused_bits;
  assign unused_bits = ^{tb_read_data[31:4], tg_read_data[3], bits_q[3]};

endmodule
